// File: rtl/mult_arbiter.sv
// mult_arbiter: two-requester front end for a shared shift-add multiplier.
// Define MULT_ARB_RR_EN for round-robin arbitration; fixed priority otherwise.
module mult_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 done0,
    output logic                 done1,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err,
    output logic                 busy,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_result
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nx;
    logic       owner;
    logic       grant;
    logic       any_req;
    logic       owner_req;
    logic       cnt_hit;
    logic [7:0] cnt;

    assign any_req   = req0 | req1;
    assign owner_req = owner ? req1 : req0;
    assign cnt_hit   = (cnt == CNT_LAST);

`ifdef MULT_ARB_RR_EN
    // last holds the requester served most recently; it loses a tie
    logic last;

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last <= grant;
        end
    end

    assign grant = req1 & (~req0 | ~last);
`else
    assign grant = req1 & ~req0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                state_nx = RUN;
            end
            RUN: begin
                if (mul_done || cnt_hit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (!owner_req) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mul_start = (state == LOAD);
        done0     = (state == DONE) && !owner;
        done1     = (state == DONE) && owner;
    end

    // operands are captured once per grant and held until the next one
    always_ff @(posedge clk) begin
        if (reset) begin
            owner  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
            mul_a  <= '0;
            mul_b  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= grant;
                        mul_a <= grant ? a1 : a0;
                        mul_b <= grant ? b1 : b0;
                    end
                end
                LOAD: begin
                    cnt <= '0;
                end
                RUN: begin
                    if (mul_done) begin
                        result <= mul_result;
                        err    <= 1'b0;
                    end else if (cnt_hit) begin
                        result <= '0;
                        err    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, sets operand width in bits; the product is 2*WIDTH bits.
REQ-002 Parameter TIMEOUT, default 64, is the maximum number of RUN cycles to wait for mul_done; legal range 2..255.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0, req1  in  1 each  request from requester 0/1, held high until the matching done is seen.
REQ-006 a0, b0, a1, b1  in  WIDTH each  operands of requester 0/1, stable while the matching req is high.
REQ-007 done0, done1  out  1 each  completion acknowledge to requester 0/1.
REQ-008 result  out  2*WIDTH  product register, valid while done0 or done1 is high.
REQ-009 err  out  1  timeout flag, valid while done0 or done1 is high.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 mul_start  out  1  single-cycle start pulse to the shared shift-add multiplier.
REQ-012 mul_a, mul_b  out  WIDTH each  registered operands driven to the multiplier.
REQ-013 mul_done  in  1  multiplier completion, level or pulse.
REQ-014 mul_result  in  2*WIDTH  multiplier product, valid when mul_done is high.

Function
REQ-015 The FSM SHALL have four states: IDLE, LOAD, RUN, DONE.
REQ-016 IDLE: if any req is high, the block SHALL select a winner, latch that requester's a/b into mul_a/mul_b, record the owner, and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-017 LOAD: mul_start=1 for exactly this one cycle, the timeout counter is cleared, then the FSM goes to RUN.
REQ-018 RUN: on mul_done=1, result<=mul_result, err<=0, and the FSM goes to DONE; otherwise the counter increments.
REQ-019 RUN timeout: when the counter reaches TIMEOUT-1 without mul_done, result<=0, err<=1, and the FSM goes to DONE; mul_done takes precedence if both occur in the same cycle.
REQ-020 DONE: the owner's done output SHALL be 1, and the other requester's done SHALL be 0.
REQ-021 DONE exit: the FSM SHALL return to IDLE on the first cycle the owner's req is sampled low (4-phase handshake).
REQ-022 A non-owner's req SHALL be held pending, never dropped, and evaluated in the next IDLE.
REQ-023 Minimum service time: one cycle in IDLE, one in LOAD, N in RUN, and at least one in DONE.
REQ-024 mul_a/mul_b SHALL hold their values from LOAD until the next arbitration, regardless of requester operand changes.
REQ-025 Arbitration SHALL occur only in IDLE; no preemption in any other state.

Reset
REQ-026 While reset is high, the FSM SHALL go to IDLE and the following SHALL be cleared: done0, done1, err, busy, mul_start, result, mul_a, mul_b, the counter and the owner.
REQ-027 Reset asserted mid-RUN SHALL abandon the operation; no done pulse SHALL follow, and a later mul_done is ignored in IDLE.
REQ-028 The round-robin pointer SHALL reset so that requester 0 has priority.

Configuration
REQ-029 With macro MULT_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests, the requester not served last wins, and the pointer updates on entry to LOAD.
REQ-030 Without MULT_ARB_RR_EN, arbitration SHALL be fixed priority: req0 always wins over req1, and no pointer register SHALL exist.

Verification
REQ-031 req0=1, a0=7, b0=9, mul_done 20 cycles after mul_start with mul_result=63 -> one mul_start pulse, mul_a=7, mul_b=9, done0=1, result=63, err=0, done1=0.
REQ-032 req0 and req1 raised in the same cycle, back-to-back -> RR build: served 0 then 1; fixed build: 0 then 1; with req0 re-raised immediately, fixed build serves 0 again and RR build serves 1.
REQ-033 mul_done never asserted, TIMEOUT=64 -> done owner high 64 cycles after LOAD, err=1, result=0.
REQ-034 reset pulsed 5 cycles into RUN, then mul_done arrives -> IDLE, all outputs 0, no done asserted, busy=0.
REQ-035 Owner holds req 10 cycles after done -> done held high 10 cycles, no new mul_start; pending req1 served only after req0 drops.
REQ-036 a0=b0=16'hFFFF, mul_result=32'hFFFE0001 -> result=32'hFFFE0001 with full 2*WIDTH width, no truncation.
